// File: rtl/pc_pkg.sv
// Shared constants and select/holder encodings for the IF-stage program-counter unit.
package pc_pkg;
  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam int          PC_INC           = 4;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_TRAP,
    SEL_REDIR,
    SEL_RET,
    SEL_CALL,
    SEL_SEQ
  } pc_sel_e;

  typedef enum logic {
    PEND_IDLE,
    PEND_HELD
  } pend_state_e;

  typedef enum logic {
    KIND_TRAP,
    KIND_REDIR
  } pend_kind_e;
endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack; a push when full silently replaces the oldest entry.
module ras #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic                         clock,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top_data,
  output logic [$clog2(RAS_DEPTH):0]   count
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q;
  logic [CW-1:0]   cnt_q;

  assign top_data = mem_q[top_q];
  assign count    = cnt_q;

  always_ff @(negedge clock) begin
    if (clear) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (pop && (cnt_q != '0)) begin
      top_q <= top_q - PW'(1);
      cnt_q <= cnt_q - CW'(1);
    end else if (push) begin
      // Pointer wrap lets the newest entry land on the oldest slot once full.
      top_q                 <= top_q + PW'(1);
      mem_q[top_q + PW'(1)] <= push_data;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: prioritised next-PC select, stall-time redirect capture, RAS prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       trap,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       is_call,
  input  logic [XLEN-1:0]            call_target,
  input  logic                       is_ret,
  output logic [XLEN-1:0]            pc_out,
  output logic                       redirect_pending,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       misalign
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  pend_state_e     pend_q, pend_d;
  pend_kind_e      kind_q, kind_d;
  logic [XLEN-1:0] held_q, held_d;

  pc_sel_e         sel;
  logic [XLEN-1:0] raw, seq_pc, ras_top;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push, ras_pop, ras_clear;
  logic            held_trap, held_redir;

  ras #(.RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clock     (clock),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .count     (ras_cnt)
  );

  always_comb begin
    seq_pc     = pc_q + XLEN'(PC_INC);
    held_trap  = (pend_q == PEND_HELD) && (kind_q == KIND_TRAP);
    held_redir = (pend_q == PEND_HELD) && (kind_q == KIND_REDIR);

    if (reset)                             sel = SEL_RESET;
    else if (trap || held_trap)            sel = SEL_TRAP;
    else if (redirect_valid || held_redir) sel = SEL_REDIR;
    else if (is_ret && (ras_cnt != '0))    sel = SEL_RET;
    else if (is_call && !is_ret)           sel = SEL_CALL;
    else                                   sel = SEL_SEQ;

    case (sel)
      SEL_RESET: raw = RESET_VECTOR;
      SEL_TRAP:  raw = TRAP_VECTOR;
      // A live redirect is newer than anything held.
      SEL_REDIR: raw = redirect_valid ? redirect_pc : held_q;
      SEL_RET:   raw = ras_top;
      SEL_CALL:  raw = call_target;
      default:   raw = seq_pc;
    endcase

    pc_d      = pc_q;
    mis_d     = 1'b0;
    pend_d    = pend_q;
    kind_d    = kind_q;
    held_d    = held_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = reset;

    if (stall) begin
      if (trap) begin
        pend_d = PEND_HELD;
        kind_d = KIND_TRAP;
      end else if (redirect_valid && !held_trap) begin
        pend_d = PEND_HELD;
        kind_d = KIND_REDIR;
        held_d = redirect_pc;
      end
    end else begin
      pc_d      = {raw[XLEN-1:2], 2'b00};
      mis_d     = |raw[1:0];
      pend_d    = PEND_IDLE;
      ras_push  = (sel == SEL_CALL);
      ras_pop   = (sel == SEL_RET);
      ras_clear = reset || (sel == SEL_TRAP);
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      mis_q  <= 1'b0;
      pend_q <= PEND_IDLE;
    end else begin
      pc_q   <= pc_d;
      mis_q  <= mis_d;
      pend_q <= pend_d;
    end
    kind_q <= kind_d;
    held_q <= held_d;
  end

  assign pc_out           = pc_q;
  assign misalign         = mis_q;
  assign redirect_pending = (pend_q == PEND_HELD);
  assign ras_count        = ras_cnt;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes model expectations, monitor compares after each falling edge.
module tb_pc_unit;
  logic        clock;
  logic        reset, stall, trap, redirect_valid, is_call, is_ret;
  logic [31:0] redirect_pc, call_target;
  logic [31:0] pc_out;
  logic        redirect_pending, misalign;
  logic [2:0]  ras_count;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .trap(trap),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .is_call(is_call), .call_target(call_target), .is_ret(is_ret),
    .pc_out(pc_out), .redirect_pending(redirect_pending),
    .ras_count(ras_count), .misalign(misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic [2:0]  cnt;
    logic        mis;
    bit          ae;
    logic [31:0] apc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_pend, m_ptrap, m_mis;
  logic [31:0] m_tgt;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, st, tr, rv, input logic [31:0] rpc,
                       input bit ic, input logic [31:0] ct, input bit ir);
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0; m_pend = 0; m_mis = 0; m_ras.delete();
    end else if (st) begin
      m_mis = 0;
      if (tr) begin m_pend = 1; m_ptrap = 1; end
      else if (rv && !(m_pend && m_ptrap)) begin m_pend = 1; m_ptrap = 0; m_tgt = rpc; end
    end else begin
      if (tr || (m_pend && m_ptrap)) begin t = 32'h100; m_ras.delete(); end
      else if (rv || m_pend) t = rv ? rpc : m_tgt;
      else if (ir && m_ras.size() > 0) t = m_ras.pop_back();
      else if (ic && !ir) begin
        t = ct;
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else t = m_pc + 32'd4;
      m_mis  = (t % 4) != 0;
      m_pc   = t - (t % 4);
      m_pend = 0;
    end
  endtask

  task automatic drive(input bit rst, st, tr, rv, input logic [31:0] rpc,
                       input bit ic, input logic [31:0] ct, input bit ir,
                       input bit ae, input logic [31:0] apc);
    exp_t e;
    @(posedge clock);
    reset = rst; stall = st; trap = tr; redirect_valid = rv; redirect_pc = rpc;
    is_call = ic; call_target = ct; is_ret = ir;
    model(rst, st, tr, rv, rpc, ic, ct, ir);
    e.pc = m_pc; e.pend = m_pend; e.cnt = 3'(m_ras.size()); e.mis = m_mis;
    e.ae = ae; e.apc = apc;
    q.push_back(e);
  endtask

  task automatic seq(input logic [31:0] apc);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, apc);
  endtask
  task automatic redir(input logic [31:0] rpc, input logic [31:0] apc);
    drive(0, 0, 0, 1, rpc, 0, 0, 0, 1, apc);
  endtask
  task automatic call(input logic [31:0] ct);
    drive(0, 0, 0, 0, 0, 1, ct, 0, 1, ct);
  endtask
  task automatic ret(input logic [31:0] apc);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, apc);
  endtask

  // Monitor: every falling edge produces one observable state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("redirect_pending", 32'(redirect_pending), 32'(e.pend));
        chk("ras_count", 32'(ras_count), 32'(e.cnt));
        chk("misalign", 32'(misalign), 32'(e.mis));
        if (e.ae) chk("pc_out_abs", pc_out, e.apc);
      end
    end
  end

  initial begin
    reset = 1; stall = 0; trap = 0; redirect_valid = 0; is_call = 0; is_ret = 0;
    redirect_pc = 0; call_target = 0;

    // Reset and free-running
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    seq(32'h4); seq(32'h8); seq(32'hC);

    // Stall with a one-cycle redirect in the middle
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'hC);
    drive(0, 1, 0, 1, 32'h40, 1, 32'h999, 0, 1, 32'hC);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'hC);
    seq(32'h40);

    // Call / return
    redir(32'h10, 32'h10);
    call(32'h80);
    seq(32'h84); seq(32'h88);
    ret(32'h14);

    // Five nested calls, depth 4
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    call(32'h100); call(32'h200); call(32'h300); call(32'h400); call(32'h500);
    ret(32'h404); ret(32'h304); ret(32'h204); ret(32'h104); ret(32'h108);

    // Trap beats redirect, clears RAS
    call(32'h600); call(32'h700);
    drive(0, 0, 1, 1, 32'h800, 0, 0, 0, 1, 32'h100);
    // Trap overrides a held redirect
    drive(0, 1, 0, 1, 32'h200, 0, 0, 0, 1, 32'h100);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h100);
    drive(0, 1, 0, 1, 32'h300, 0, 0, 0, 1, 32'h100);
    seq(32'h100);

    // Misaligned redirect and wraparound
    redir(32'h42, 32'h40);
    seq(32'h44);
    redir(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    seq(32'h0);
    // Return with empty RAS, call+ret together, reset during stall with pending
    ret(32'h4);
    drive(0, 0, 0, 0, 0, 1, 32'h900, 1, 1, 32'h8);
    drive(0, 1, 0, 1, 32'h500, 0, 0, 0, 1, 32'h8);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    seq(32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit rst, st, tr, rv, ic, ir;
      logic [31:0] rpc, ct;
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 25);
      tr  = ($urandom_range(0, 99) < 5);
      rv  = ($urandom_range(0, 99) < 10);
      ic  = ($urandom_range(0, 99) < 20);
      ir  = ($urandom_range(0, 99) < 15);
      rpc = $urandom;
      ct  = $urandom;
      drive(rst, st, tr, rv, rpc, ic, ct, ir, 0, 32'h0);
    end

    @(posedge clock);
    reset = 0; stall = 1; trap = 0; redirect_valid = 0; is_call = 0; is_ret = 0;
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
